// File: rtl/key_conditioner.sv
// key_conditioner: synchronises, debounces and edge-detects an active-low push-button.
// The debounced level a_out drives the A input of the downstream K1/K2 control FSM.
// Optional build macro KEY_COND_TOGGLE_EN turns a_out into a press-toggled flop.
`timescale 1ns / 1ps

module key_conditioner #(
    parameter int unsigned TICK_DIV  = 500,   // clk cycles per debounce sample tick
    parameter int unsigned DEB_TICKS = 2000   // stable ticks needed to accept a new level
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    input  logic en,
    output logic a_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(DEB_TICKS + 1);
    // A one-cycle prescaler still needs a 1-bit register; it simply never leaves 0.
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICKS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam logic [1:0] ST_UP     = 2'd0;
    localparam logic [1:0] ST_DN_CHK = 2'd1;
    localparam logic [1:0] ST_DOWN   = 2'd2;
    localparam logic [1:0] ST_UP_CHK = 2'd3;

    logic             sync1_q, sync2_q;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic             a_q, a_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             pressed;
    logic             tick;

    assign pressed = ~sync2_q;
    assign tick    = (pre_q == PRE_LAST);

    // Two-flop synchroniser; keeps sampling even while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic: prescaler, debounce FSM and registered pulse/level outputs.
    always_comb begin
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        a_d     = a_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (en) begin
            pre_d = tick ? '0 : pre_q + 1'b1;

            case (state_q)
                ST_UP: begin
                    if (pressed) begin
                        state_d = ST_DN_CHK;
                        cnt_d   = '0;
                    end
                end
                ST_DN_CHK: begin
                    if (!pressed) begin
                        state_d = ST_UP;
                        cnt_d   = '0;
                    end else if (tick) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_DOWN;
                            rise_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_DOWN: begin
                    if (!pressed) begin
                        state_d = ST_UP_CHK;
                        cnt_d   = '0;
                    end
                end
                ST_UP_CHK: begin
                    if (pressed) begin
                        state_d = ST_DOWN;
                        cnt_d   = '0;
                    end else if (tick) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_UP;
                            fall_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_UP;
                    cnt_d   = '0;
                end
            endcase

`ifdef KEY_COND_TOGGLE_EN
            if (rise_d) a_d = ~a_q;
`else
            if (rise_d) a_d = 1'b1;
            if (fall_d) a_d = 1'b0;
`endif
        end
    end

    // State registers; a_out and the pulses update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_UP;
            a_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            a_q     <= a_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign a_out      = a_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = (state_q == ST_DN_CHK) || (state_q == ST_UP_CHK);

endmodule
